// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
//   Run-time programmable clock divider built entirely in the clk domain.
//   A half-period counter toggles clk_out every (H+1) enabled cycles, giving
//   an output period of 2*(H+1) clk cycles with an exact 50% duty cycle.
//   A new H is held in a shadow register and is adopted only at the falling
//   toggle. Each period therefore runs on one value, so a change of H
//   cannot produce a runt pulse.
//
// Parameters
//   WIDTH        width of the half-period counter and divisor registers
//   RESET_HALF   half-period value in use after reset
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   en           count enable; low freezes the divider phase
//   half_period  requested half-period H
//   load         one-cycle strobe capturing half_period
//   clk_out      divided output (registered)
//   tick         one-cycle strobe on the first high cycle of clk_out
//   pending      a captured value waits for the next period boundary
// ---------------------------------------------------------------------------
module clk_div_prog #(
  parameter int unsigned           WIDTH      = 18,
  parameter logic [WIDTH-1:0]      RESET_HALF = WIDTH'(131071)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] half_period,
  input  logic             load,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] act_half_q, act_half_d;
  logic [WIDTH-1:0] shadow_q,   shadow_d;
  logic             clk_out_q,  clk_out_d;
  logic             tick_q,     tick_d;
  logic             pending_q,  pending_d;

  logic toggle;
  logic boundary;

  // Toggle point: the counter has reached the active half-period while enabled.
  // The falling toggle (clk_out currently high) is the period boundary.
  assign toggle   = en && (cnt_q == act_half_q);
  assign boundary = toggle && clk_out_q;

  always_comb begin
    cnt_d      = cnt_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;
    act_half_d = act_half_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;

    if (en) begin
      if (toggle) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
        // tick marks the 0->1 transition only
        tick_d    = ~clk_out_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end

    // A load on the boundary cycle bypasses the shadow so the freshest value
    // governs the very next period. Any older shadow value is dropped.
    if (load && boundary) begin
      shadow_d   = half_period;
      act_half_d = half_period;
      pending_d  = 1'b0;
    end else if (load) begin
      shadow_d  = half_period;
      pending_d = 1'b1;
    end else if (boundary && pending_q) begin
      act_half_d = shadow_q;
      pending_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      pending_q  <= 1'b0;
      act_half_q <= RESET_HALF;
      shadow_q   <= RESET_HALF;
    end else begin
      cnt_q      <= cnt_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      pending_q  <= pending_d;
      act_half_q <= act_half_d;
      shadow_q   <= shadow_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

  localparam int W = 4;
  localparam logic [W-1:0] RH = 4'd3;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         load;
  logic [W-1:0] half_period;
  logic         clk_out;
  logic         tick;
  logic         pending;

  clk_div_prog #(.WIDTH(W), .RESET_HALF(RH)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .half_period (half_period),
    .load        (load),
    .clk_out     (clk_out),
    .tick        (tick),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboard of expected {clk_out, tick, pending} after each clock edge.
  logic [2:0] sbq[$];

  // Reference model state
  logic [W-1:0] m_cnt, m_act, m_sh;
  logic         m_out, m_tick, m_pend;

  task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_cnt  = '0;
    m_out  = 1'b0;
    m_tick = 1'b0;
    m_pend = 1'b0;
    m_act  = RH;
    m_sh   = RH;
    sbq.delete();
  endtask

  // Predict the state after the coming edge from current inputs and push it.
  task automatic model_push();
    logic         at_top, fall;
    logic [W-1:0] n_cnt, n_act, n_sh;
    logic         n_out, n_tick, n_pend;
    n_cnt = m_cnt; n_act = m_act; n_sh = m_sh;
    n_out = m_out; n_tick = 1'b0; n_pend = m_pend;
    at_top = (m_cnt == m_act);
    fall   = en && at_top && m_out;
    if (en) begin
      if (at_top) begin
        n_cnt  = '0;
        n_out  = !m_out;
        n_tick = !m_out;
      end else begin
        n_cnt = m_cnt + 4'd1;
      end
    end
    if (load) begin
      n_sh   = half_period;
      n_pend = 1'b1;
    end
    if (fall && load) begin
      n_act  = half_period;
      n_pend = 1'b0;
    end else if (fall && m_pend) begin
      n_act  = m_sh;
      n_pend = 1'b0;
    end
    m_cnt = n_cnt; m_act = n_act; m_sh = n_sh;
    m_out = n_out; m_tick = n_tick; m_pend = n_pend;
    sbq.push_back({n_out, n_tick, n_pend});
  endtask

  task automatic cycle(input string tag);
    logic [2:0] e;
    model_push();
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check3(tag, {clk_out, tick, pending}, e);
  endtask

  // Advance until clk_out reaches lvl; n is the number of edges taken.
  task automatic wait_level(input logic lvl, input string tag, output int n);
    n = 0;
    while (clk_out !== lvl && n < 40) begin
      cycle(tag);
      n++;
    end
  endtask

  initial begin
    int n;
    int ticks;
    int toggles;
    logic prev;

    reset = 1'b0; en = 1'b0; load = 1'b0; half_period = '0;
    model_reset();
    #12;
    check3("reset_state", {clk_out, tick, pending}, 3'b000);

    @(posedge clk); #1;
    reset = 1'b1; en = 1'b1;

    // 1: reset divisor, period 8, tick on each rise
    wait_level(1'b1, "t1_run", n);
    check_int("t1_first_rise", n, 4);
    check3("t1_rise", {clk_out, tick, pending}, 3'b110);
    wait_level(1'b0, "t1_run", n);
    check_int("t1_high_len", n, 4);
    wait_level(1'b1, "t1_run", n);
    check_int("t1_low_len", n, 4);
    check3("t1_rise2", {clk_out, tick, pending}, 3'b110);

    // 2: load H=0 during the low phase
    wait_level(1'b0, "t2_run", n);
    load = 1'b1; half_period = 4'd0;
    cycle("t2_load");
    load = 1'b0;
    check3("t2_pending", {clk_out, tick, pending}, 3'b001);
    wait_level(1'b1, "t2_run", n);
    check3("t2_pend_high", {clk_out, tick, pending}, 3'b111);
    wait_level(1'b0, "t2_run", n);
    check3("t2_boundary", {clk_out, tick, pending}, 3'b000);
    ticks = 0; toggles = 0; prev = clk_out;
    for (int i = 0; i < 6; i++) begin
      cycle("t2_div2");
      if (tick) ticks++;
      if (clk_out !== prev) toggles++;
      prev = clk_out;
    end
    check_int("t2_ticks", ticks, 3);
    check_int("t2_toggles", toggles, 6);

    // back to H=3
    load = 1'b1; half_period = 4'd3;
    cycle("t3_setup");
    load = 1'b0;
    wait_level(1'b1, "t3_setup", n);
    wait_level(1'b0, "t3_setup", n);
    wait_level(1'b1, "t3_setup", n);
    check_int("t3_h3_low", n, 4);

    // 3: load H=1 in the 2nd cycle of the high phase
    cycle("t3_run");
    load = 1'b1; half_period = 4'd1;
    cycle("t3_load");
    load = 1'b0;
    wait_level(1'b0, "t3_run", n);
    check_int("t3_high_rest", n, 2);
    check3("t3_boundary", {clk_out, tick, pending}, 3'b000);
    wait_level(1'b1, "t3_run", n);
    check_int("t3_new_low", n, 2);
    wait_level(1'b0, "t3_run", n);
    check_int("t3_new_high", n, 2);

    // back to H=3
    load = 1'b1; half_period = 4'd3;
    cycle("t4_setup");
    load = 1'b0;
    wait_level(1'b1, "t4_setup", n);
    wait_level(1'b0, "t4_setup", n);
    wait_level(1'b1, "t4_setup", n);
    check_int("t4_h3_low", n, 4);

    // 4: freeze mid high phase
    cycle("t4_run");
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle("t4_frozen");
      check3("t4_hold", {clk_out, tick, pending}, 3'b100);
    end
    en = 1'b1;
    wait_level(1'b0, "t4_run", n);
    check_int("t4_high_rest", n, 3);

    // 5: load on the boundary cycle overrides a pending shadow
    wait_level(1'b1, "t5_run", n);
    load = 1'b1; half_period = 4'd1;
    cycle("t5_load1");
    load = 1'b0;
    cycle("t5_run");
    cycle("t5_run");
    check3("t5_pend", {clk_out, tick, pending}, 3'b101);
    load = 1'b1; half_period = 4'd5;
    cycle("t5_load5");
    load = 1'b0;
    check3("t5_boundary", {clk_out, tick, pending}, 3'b000);
    wait_level(1'b1, "t5_run", n);
    check_int("t5_low_len", n, 6);
    wait_level(1'b0, "t5_run", n);
    check_int("t5_high_len", n, 6);

    // 6: asynchronous reset mid phase with a pending load
    load = 1'b1; half_period = 4'd2;
    cycle("t6_load");
    load = 1'b0;
    cycle("t6_run");
    check3("t6_pre", {clk_out, tick, pending}, 3'b001);
    wait_level(1'b1, "t6_run", n);
    cycle("t6_run");
    check3("t6_pre_high", {clk_out, tick, pending}, 3'b101);
    #2;
    reset = 1'b0;
    #1;
    check3("t6_async", {clk_out, tick, pending}, 3'b000);
    model_reset();
    @(posedge clk); #1;
    check3("t6_held", {clk_out, tick, pending}, 3'b000);
    reset = 1'b1;
    wait_level(1'b1, "t6_run", n);
    check_int("t6_first_rise", n, 4);
    wait_level(1'b0, "t6_run", n);
    check_int("t6_high_len", n, 4);
    wait_level(1'b1, "t6_run", n);
    check_int("t6_low_len", n, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Parametrised, fully synchronous, run-time programmable clock divider.
- Generates a divided clock-like signal `clk_out` and a one-cycle `tick` strobe, both registered in the single `clk` domain.
- Replaces fixed ripple toggle-flop chains: no derived clocks, a divisor change without glitches, and an enable input.
- Downstream logic uses `tick` as a clock enable. `clk_out` is used only for observation or for slow external pins.

Parameters:
- WIDTH, 18, width of the half-period counter and of the divisor registers.
- RESET_HALF, 131071, half-period value loaded at reset. The default gives divide-by-2^18. RESET_HALF must be less than 2^WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; when low, the divider phase freezes.
- half_period  input  WIDTH  requested half-period value H. The output period is 2*(H+1) clk cycles.
- load  input  1  one-cycle strobe that captures half_period.
- clk_out  output  1  divided output, registered.
- tick  output  1  high for exactly one cycle: the first cycle in which clk_out is 1.
- pending  output  1  a loaded value is waiting for the next period boundary.

Behaviour:
- Internal state:
  - cnt[WIDTH-1:0], the counter.
  - act_half[WIDTH-1:0], the half-period in use.
  - shadow[WIDTH-1:0], the captured value not yet applied.
- Reset (reset=0, asynchronous, no clock edge needed):
  - cnt=0, clk_out=0, tick=0, pending=0, act_half=RESET_HALF, shadow=RESET_HALF.
  - Any pending load is discarded.
- Counting (en=1):
  - If cnt != act_half: cnt <= cnt+1, clk_out holds, tick <= 0.
  - If cnt == act_half (toggle point): cnt <= 0, clk_out <= ~clk_out, tick <= ~clk_out. So tick rises together with clk_out 0->1.
- Period boundary = toggle point with clk_out==1, i.e. the falling toggle.
  - At a boundary with pending=1: act_half <= shadow, pending <= 0.
  - Rising toggles never change act_half. The high and low phases of every period therefore use the same H, and the duty cycle is exactly 50%.
- Load:
  - load=1 captures shadow <= half_period and sets pending <= 1, irrespective of en.
  - A second load before the boundary overwrites shadow; last write wins.
- Simultaneous load and boundary (en=1): act_half <= half_period directly, pending <= 0. The new value governs the next period. An older shadow value is dropped.
- en=0:
  - cnt, clk_out and act_half hold. tick <= 0.
  - Load capture still works, but the value is not applied until a boundary occurs with en=1.
  - On re-enable, counting resumes from the frozen cnt; no phase reset.
- Latency:
  - clk_out and tick change on the clk edge at which cnt==act_half. The output is registered, so there is no combinational path from any input to any output.
- Arithmetic:
  - cnt never exceeds act_half, so there is no wrap.
  - H=0 gives divide-by-2. H=2^WIDTH-1 gives divide-by-2^(WIDTH+1), the maximum.
- Freezing act_half until the boundary is what keeps a change of H glitch-free. A new H that is smaller than the current cnt cannot truncate a phase, because the new value only takes effect once cnt has returned to 0.

Test Plan:
1. WIDTH=4, RESET_HALF=3, en=1 after reset release -> clk_out repeats 4 high / 4 low (period 8). tick pulses once per 8 cycles, aligned to the clk_out rise. pending=0.
2. load with half_period=0 while clk_out=0 -> pending=1 until the next falling toggle, then clear. Afterwards clk_out toggles every cycle and tick is high every 2nd cycle.
3. H=3; load half_period=1 in the 2nd cycle of the high phase -> current high phase still lasts 4 cycles. Pending clears at the falling toggle, and each following phase lasts 2 cycles (period 4). No runt pulse.
4. H=3; en=0 for 5 cycles in the middle of a high phase -> clk_out stays 1 and tick stays 0. The high phase totals 4 enabled cycles plus 5 frozen cycles; cnt resumes where it stopped.
5. load half_period=5 asserted exactly on the falling-toggle cycle with pending=1 (shadow=1) -> act_half=5. pending is 0 in the next cycle, the period is 12, and the shadow value 1 is never used.
6. reset driven low asynchronously mid-phase with pending=1 -> clk_out, tick and pending are 0 before the next clk edge. After release the period reverts to 2*(RESET_HALF+1).
